// File: rtl/accumulation_buffer_scheduler.sv
// accumulation_buffer_scheduler: read-modify-write accumulation into a double-banked buffer plus skid-buffered drain.
// Define ACCUM_SATURATE_EN for signed saturating accumulation instead of wrapping add.
module accumulation_buffer_scheduler #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 7,
  parameter int BANK_DEPTH      = 128,
  parameter int PASS_WIDTH      = 8,
  parameter int TILE_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BANK_ADDR_WIDTH:0]   cfg_num_addr,
  input  logic [PASS_WIDTH-1:0]      cfg_num_passes,
  input  logic [TILE_WIDTH-1:0]      cfg_num_tiles,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic                       switch_banks,
  output logic                       ren,
  output logic [BANK_ADDR_WIDTH-1:0] radr,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       wen,
  output logic [BANK_ADDR_WIDTH-1:0] wadr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       ren_wb,
  output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
  input  logic [DATA_WIDTH-1:0]      rdata_wb
);
  localparam int AW = BANK_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [AW:0] DEPTH = (AW+1)'(BANK_DEPTH);
  localparam logic [2:0] S_IDLE = 3'd0, S_ACCUM = 3'd1, S_SWAIT = 3'd2, S_SWITCH = 3'd3, S_FINAL = 3'd4;
  logic [2:0] state;
  logic [AW:0] n_addr, addr, wb_addr;
  logic [PASS_WIDTH-1:0] n_pass, pass;
  logic [TILE_WIDTH-1:0] n_tile, tile;
  logic pend;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] held, raw, sum;
  logic wb_active, inflight, inflight_last;
  logic [DW-1:0] sk_data [2];
  logic [1:0] sk_last, sk_cnt;
  logic sk_wp, sk_rp;
  logic beat, last_addr, last_pass, wb_last, wb_idle, pop, can_start;
  assign in_ready     = state == S_ACCUM;
  assign beat         = in_valid & in_ready;
  assign last_addr    = addr == n_addr - 1'b1;
  assign last_pass    = pass == n_pass - 1'b1;
  assign wb_last      = wb_addr == n_addr - 1'b1;
  assign busy         = state != S_IDLE;
  assign switch_banks = state == S_SWITCH;
  assign can_start    = start && state == S_IDLE && cfg_num_addr != '0 && cfg_num_addr <= DEPTH
                        && cfg_num_passes != '0 && cfg_num_tiles != '0;
  assign ren   = beat && pass != '0;
  assign radr  = ren ? addr[AW-1:0] : '0;
  assign wen   = pend | (beat && pass == '0);
  assign wadr  = pend ? pend_addr : (wen ? addr[AW-1:0] : '0);
  assign wdata = pend ? sum : (wen ? in_data : '0);
  assign raw   = rdata + held;
`ifdef ACCUM_SATURATE_EN
  // Overflow only when both operands share a sign the result does not.
  assign sum = (rdata[DW-1] == held[DW-1] && raw[DW-1] != held[DW-1])
             ? (held[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : raw;
`else
  assign sum = raw;
`endif
  assign out_valid = sk_cnt != 2'd0;
  assign out_data  = sk_data[sk_rp];
  assign out_last  = out_valid & sk_last[sk_rp];
  assign pop       = out_valid & out_ready;
  assign wb_idle   = !wb_active && !inflight;
  // Counting the same-cycle pop keeps the drain at one word per cycle.
  assign ren_wb    = wb_active && (sk_cnt + {1'b0, inflight} - {1'b0, pop}) < 2'd2;
  assign radr_wb   = wb_addr[AW-1:0];
  assign done      = state == S_FINAL && wb_idle && !out_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_addr    <= '0;
      n_pass    <= '0;
      n_tile    <= '0;
      addr      <= '0;
      pass      <= '0;
      tile      <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      held      <= '0;
    end else begin
      pend <= ren;
      if (ren) begin
        held      <= in_data;
        pend_addr <= addr[AW-1:0];
      end
      case (state)
        S_IDLE: if (can_start) begin
          n_addr <= cfg_num_addr;
          n_pass <= cfg_num_passes;
          n_tile <= cfg_num_tiles;
          addr   <= '0;
          pass   <= '0;
          tile   <= '0;
          state  <= S_ACCUM;
        end
        S_ACCUM: if (beat) begin
          addr <= last_addr ? '0 : addr + 1'b1;
          if (last_addr && last_pass) state <= S_SWAIT;
          else if (last_addr) pass <= pass + 1'b1;
        end
        S_SWAIT: if (wb_idle && !pend) state <= S_SWITCH;
        S_SWITCH: begin
          tile  <= tile + 1'b1;
          pass  <= '0;
          state <= tile == n_tile - 1'b1 ? S_FINAL : S_ACCUM;
        end
        S_FINAL: if (done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_active     <= 1'b0;
      wb_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      sk_data[0]    <= '0;
      sk_data[1]    <= '0;
      sk_last       <= '0;
      sk_cnt        <= '0;
      sk_wp         <= 1'b0;
      sk_rp         <= 1'b0;
    end else begin
      if (switch_banks) begin
        wb_active <= 1'b1;
        wb_addr   <= '0;
      end else if (ren_wb) begin
        wb_addr <= wb_addr + 1'b1;
        if (wb_last) wb_active <= 1'b0;
      end
      inflight      <= ren_wb;
      inflight_last <= ren_wb & wb_last;
      if (inflight) begin
        sk_data[sk_wp] <= rdata_wb;
        sk_last[sk_wp] <= inflight_last;
        sk_wp          <= ~sk_wp;
      end
      if (pop) sk_rp <= ~sk_rp;
      sk_cnt <= sk_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_accumulation_buffer_scheduler.sv
// tb_accumulation_buffer_scheduler: directed tests with a behavioural double-banked buffer.
module tb_accumulation_buffer_scheduler;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW:0] cfg_num_addr = '0;
  logic [7:0] cfg_num_passes = '0, cfg_num_tiles = '0;
  logic busy, done, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic [DW-1:0] in_data = '0, out_data, rdata, wdata, rdata_wb;
  logic switch_banks, ren, wen, ren_wb;
  logic [AW-1:0] radr, wadr, radr_wb;
  logic [DW-1:0] bank [2][128];
  logic act;
  int total = 0, bad = 0, orm = 0;
  int n_sw = 0, n_ren = 0, n_done = 0, n_wmatch = 0;
  logic [DW-1:0] oq [$];
  logic lq [$];

  accumulation_buffer_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_addr(cfg_num_addr),
    .cfg_num_passes(cfg_num_passes), .cfg_num_tiles(cfg_num_tiles), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .switch_banks(switch_banks),
    .ren(ren), .radr(radr), .rdata(rdata), .wen(wen), .wadr(wadr), .wdata(wdata),
    .ren_wb(ren_wb), .radr_wb(radr_wb), .rdata_wb(rdata_wb)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act <= 1'b0;
      rdata <= '0;
      rdata_wb <= '0;
    end else begin
      if (switch_banks) act <= ~act;
      if (wen) bank[act][wadr] <= wdata;
      rdata <= (wen && wadr == radr) ? wdata : bank[act][radr];
      rdata_wb <= bank[~act][radr_wb];
    end

  always begin
    @(posedge clk);
    #1 out_ready = (orm == 0) ? 1'b1 : (orm == 1) ? ~out_ready : 1'b0;
  end

  always @(negedge clk)
    if (rst_n) begin
      if (out_valid && out_ready) begin
        oq.push_back(out_data);
        lq.push_back(out_last);
      end
      if (switch_banks) n_sw++;
      if (ren) n_ren++;
      if (done) n_done++;
      if (wen && wdata == {57'b0, wadr}) n_wmatch++;
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] din(input int kind, input int t, input int p, input int a);
    if (kind == 0) return 64'(a);
    if (kind == 1) return 64'(t * 100 + a);
    if (p == 0) return a == 0 ? MAXP : MINN;
    return a == 0 ? 64'd1 : {64{1'b1}};
  endfunction

  task automatic start_job(input int n, input int p, input int t);
    @(posedge clk);
    #1 cfg_num_addr = (AW+1)'(n);
    cfg_num_passes = 8'(p);
    cfg_num_tiles = 8'(t);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cfg_num_addr = '0;
    cfg_num_passes = '0;
    cfg_num_tiles = '0;
  endtask

  task automatic feed(input int n, input int p, input int t, input int kind);
    for (int ti = 0; ti < t; ti++)
      for (int pi = 0; pi < p; pi++)
        for (int a = 0; a < n; a++) begin
          bit hs = 0;
          in_valid = 1'b1;
          in_data = din(kind, ti, pi, a);
          for (int k = 0; k < 3000 && !hs; k++) begin
            @(negedge clk);
            if (in_ready) begin
              hs = 1;
              @(posedge clk);
              #1;
            end
          end
          if (!hs) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int k = 0; k < 3000 && n_done == base; k++) @(negedge clk);
    chk("done_seen", 64'(n_done - base), 64'd1);
  endtask

  initial begin
    int bo, bs, br, bd, bw;
    #12;
    chk("reset_outs", {busy, done, in_ready, out_valid, out_last, switch_banks, ren, wen, ren_wb}, 0);
    chk("reset_data", out_data | wdata | 64'(radr) | 64'(wadr) | 64'(radr_wb), 0);
    rst_n = 1'b1;
    orm = 0;
    // Test 1: single pass, single tile
    bo = oq.size(); bs = n_sw; br = n_ren; bd = n_done; bw = n_wmatch;
    start_job(16, 1, 1);
    chk("t1_busy", 64'(busy), 1);
    feed(16, 1, 1, 0);
    wait_done(bd);
    chk("t1_writes", 64'(n_wmatch - bw), 16);
    chk("t1_switch", 64'(n_sw - bs), 1);
    chk("t1_ren", 64'(n_ren - br), 0);
    chk("t1_count", 64'(oq.size() - bo), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t1_data", oq[bo+i], 64'(i));
      chk("t1_last", 64'(lq[bo+i]), 64'(i == 15));
    end
    @(negedge clk);
    chk("t1_idle", 64'(busy), 0);
    // Test 2: three passes accumulate 3*i
    bo = oq.size(); bs = n_sw; br = n_ren; bd = n_done;
    start_job(16, 3, 1);
    feed(16, 3, 1, 0);
    wait_done(bd);
    chk("t2_ren", 64'(n_ren - br), 32);
    chk("t2_count", 64'(oq.size() - bo), 16);
    for (int i = 0; i < 16; i++) chk("t2_data", oq[bo+i], 64'(3 * i));
    // Test 3: three tiles, out_ready toggling
    orm = 1;
    bo = oq.size(); bs = n_sw; bd = n_done;
    start_job(8, 2, 3);
    feed(8, 2, 3, 1);
    wait_done(bd);
    chk("t3_switch", 64'(n_sw - bs), 3);
    chk("t3_count", 64'(oq.size() - bo), 24);
    for (int i = 0; i < 24; i++) begin
      chk("t3_data", oq[bo+i], 64'(2 * ((i / 8) * 100 + i % 8)));
      chk("t3_last", 64'(lq[bo+i]), 64'(i % 8 == 7));
    end
    // Test 4: stalled drain withholds the second switch
    orm = 2;
    bo = oq.size(); bs = n_sw; bd = n_done;
    start_job(4, 1, 2);
    feed(4, 1, 2, 1);
    repeat (20) @(negedge clk);
    chk("t4_switch_held", 64'(n_sw - bs), 1);
    chk("t4_in_ready", 64'(in_ready), 0);
    chk("t4_busy", 64'(busy), 1);
    orm = 0;
    wait_done(bd);
    chk("t4_switch", 64'(n_sw - bs), 2);
    chk("t4_count", 64'(oq.size() - bo), 8);
    for (int i = 0; i < 8; i++) chk("t4_data", oq[bo+i], 64'((i / 4) * 100 + i % 4));
    // Test 5: overflow at both extremes
    bo = oq.size(); bd = n_done;
    start_job(2, 2, 1);
    feed(2, 2, 1, 5);
    wait_done(bd);
    chk("t5_count", 64'(oq.size() - bo), 2);
`ifdef ACCUM_SATURATE_EN
    chk("t5_pos", oq[bo], MAXP);
    chk("t5_neg", oq[bo+1], MINN);
`else
    chk("t5_pos", oq[bo], MINN);
    chk("t5_neg", oq[bo+1], MAXP);
`endif
    // Test 6: reset mid-job, then illegal starts
    bs = n_sw;
    start_job(8, 1, 1);
    in_valid = 1'b1;
    in_data = 64'd5;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_outs", {busy, done, in_ready, out_valid, out_last, switch_banks, ren, wen, ren_wb}, 0);
    chk("t6_rst_data", out_data | wdata | 64'(wadr), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_switch", 64'(n_sw - bs), 0);
    start_job(0, 1, 1);
    @(negedge clk);
    chk("t6_zero_addr", 64'(busy), 0);
    start_job(129, 1, 1);
    @(negedge clk);
    chk("t6_big_addr", 64'(busy), 0);
    start_job(4, 0, 1);
    @(negedge clk);
    chk("t6_zero_pass", 64'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
